io_bus_sequencer: RTL and testbench

- Two-requester controller for the 16-bit byte-laned I/O bus that serves the virtual/peripheral I/O devices.
- Requester 0 is the CPU load/store path; requester 1 is the DMA/loader.
- Arbitrates between the two requesters, then runs each access as a timed SETUP -> STROBE -> HOLD sequence on rd_n/wr_n.
- Drives the byte chip-selects and device select, captures read data, and returns a one-cycle ack.

---
 rtl/io_seq_pkg.sv | 28 ++
 rtl/io_seq_arbiter.sv | 36 +++
 rtl/io_bus_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_io_bus_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_seq_pkg.sv
// io_seq_pkg: state encoding, bus idle levels and phase-counter sizing shared by
// io_bus_sequencer and io_seq_arbiter.
package io_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ZERO,
        S_SETUP,
        S_STROBE,
        S_HOLD
    } seq_state_t;

    localparam logic BUS_STROBE_IDLE = 1'b1;
    localparam logic BUS_CS_IDLE     = 1'b1;
    localparam logic BUS_OE_IDLE     = 1'b0;

    // Counter loads (cycles - 1), so it only has to reach max - 1.
    function automatic int unsigned phase_cnt_width(input int unsigned a,
                                                    input int unsigned b,
                                                    input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 2) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/io_seq_arbiter.sv
// io_seq_arbiter: 2-way grant select. Fixed priority (req0 first) by default;
// round-robin on simultaneous requests when IO_SEQ_ROUND_ROBIN_EN is defined.
module io_seq_arbiter
    import io_seq_pkg::*;
(
`ifdef IO_SEQ_ROUND_ROBIN_EN
    input  logic clk,
    input  logic reset,
    input  logic take,
`endif
    input  logic req0_valid,
    input  logic req1_valid,
    output logic grant_any,
    output logic grant_idx
);

    assign grant_any = req0_valid | req1_valid;

`ifdef IO_SEQ_ROUND_ROBIN_EN
    logic last_idx;

    always_comb begin
        if (req0_valid && req1_valid) grant_idx = ~last_idx;
        else                          grant_idx = ~req0_valid;
    end

    // Reset value 1 makes req0 the first winner of a tie.
    always_ff @(posedge clk) begin
        if (reset)                  last_idx <= 1'b1;
        else if (take && grant_any) last_idx <= grant_idx;
    end
`else
    assign grant_idx = ~req0_valid;
`endif

endmodule

// File: rtl/io_bus_sequencer.sv
// io_bus_sequencer: two-requester SETUP/STROBE/HOLD sequencer for the 16-bit byte-laned
// I/O bus. Define IO_SEQ_ROUND_ROBIN_EN for round-robin arbitration instead of fixed priority.
module io_bus_sequencer
    import io_seq_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 15,
    parameter int unsigned SETUP_CYCLES  = 1,
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [15:0]           req0_wdata,
    input  logic [1:0]            req0_be,
    input  logic                  req0_sel,
    output logic                  req0_ack,
    output logic [15:0]           req0_rdata,
    input  logic                  req1_valid,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [15:0]           req1_wdata,
    input  logic [1:0]            req1_be,
    input  logic                  req1_sel,
    output logic                  req1_ack,
    output logic [15:0]           req1_rdata,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [15:0]           bus_wdata,
    output logic                  bus_data_oe,
    input  logic [15:0]           bus_rdata,
    output logic                  bus_rd_n,
    output logic                  bus_wr_n,
    output logic                  bus_csh_n,
    output logic                  bus_csl_n,
    output logic                  bus_select_dev
);

    localparam int unsigned CW = phase_cnt_width(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);
    localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    seq_state_t            state;
    logic [CW-1:0]         cnt;
    logic                  cur;
    logic                  lat_we;
    logic [1:0]            lat_be;
    logic [15:0]           rd_buf;

    logic                  grant_any;
    logic                  grant_idx;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [15:0]           sel_wdata;
    logic [1:0]            sel_be;
    logic                  sel_dev;
    logic [15:0]           rd_masked;
    logic [15:0]           ack_data;
    logic                  ack_now;

    io_seq_arbiter u_arb (
`ifdef IO_SEQ_ROUND_ROBIN_EN
        .clk        (clk),
        .reset      (reset),
        .take       (state == S_IDLE),
`endif
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .grant_any  (grant_any),
        .grant_idx  (grant_idx)
    );

    always_comb begin
        sel_we    = grant_idx ? req1_we    : req0_we;
        sel_addr  = grant_idx ? req1_addr  : req0_addr;
        sel_wdata = grant_idx ? req1_wdata : req0_wdata;
        sel_be    = grant_idx ? req1_be    : req0_be;
        sel_dev   = grant_idx ? req1_sel   : req0_sel;
    end

    // With a one-cycle HOLD the ack coincides with the sampling edge, so the
    // masked bus value is forwarded directly instead of going through rd_buf.
    always_comb begin
        rd_masked = bus_rdata & {{8{lat_be[1]}}, {8{lat_be[0]}}};
        ack_data  = (state == S_STROBE) ? rd_masked : rd_buf;
        ack_now   = ((state == S_STROBE) && (cnt == '0) && (HOLD_CYCLES == 1)) ||
                    ((state == S_HOLD) && (cnt == CNT_ONE));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            cnt            <= '0;
            cur            <= 1'b0;
            lat_we         <= 1'b0;
            lat_be         <= '0;
            rd_buf         <= '0;
            req0_ack       <= 1'b0;
            req1_ack       <= 1'b0;
            req0_rdata     <= '0;
            req1_rdata     <= '0;
            bus_addr       <= '0;
            bus_wdata      <= '0;
            bus_select_dev <= 1'b0;
            bus_data_oe    <= BUS_OE_IDLE;
            bus_rd_n       <= BUS_STROBE_IDLE;
            bus_wr_n       <= BUS_STROBE_IDLE;
            bus_csh_n      <= BUS_CS_IDLE;
            bus_csl_n      <= BUS_CS_IDLE;
        end else begin
            req0_ack <= 1'b0;
            req1_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        cur    <= grant_idx;
                        lat_we <= sel_we;
                        lat_be <= sel_be;
                        if (sel_be == 2'b00) begin
                            state <= S_ZERO;
                            if (grant_idx) begin
                                req1_ack   <= 1'b1;
                                req1_rdata <= '0;
                            end else begin
                                req0_ack   <= 1'b1;
                                req0_rdata <= '0;
                            end
                        end else begin
                            state          <= S_SETUP;
                            cnt            <= SETUP_LAST;
                            bus_addr       <= sel_addr;
                            bus_wdata      <= sel_wdata;
                            bus_select_dev <= sel_dev;
                            bus_csh_n      <= ~sel_be[1];
                            bus_csl_n      <= ~sel_be[0];
                            bus_data_oe    <= sel_we;
                        end
                    end
                end
                S_ZERO: state <= S_IDLE;
                S_SETUP: begin
                    if (cnt == '0) begin
                        state    <= S_STROBE;
                        cnt      <= STROBE_LAST;
                        bus_rd_n <= lat_we;
                        bus_wr_n <= ~lat_we;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                S_STROBE: begin
                    if (cnt == '0) begin
                        state    <= S_HOLD;
                        cnt      <= HOLD_LAST;
                        bus_rd_n <= BUS_STROBE_IDLE;
                        bus_wr_n <= BUS_STROBE_IDLE;
                        if (!lat_we) rd_buf <= rd_masked;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                S_HOLD: begin
                    if (cnt == '0) begin
                        state       <= S_IDLE;
                        bus_csh_n   <= BUS_CS_IDLE;
                        bus_csl_n   <= BUS_CS_IDLE;
                        bus_data_oe <= BUS_OE_IDLE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (ack_now) begin
                if (cur) begin
                    req1_ack <= 1'b1;
                    if (!lat_we) req1_rdata <= ack_data;
                end else begin
                    req0_ack <= 1'b1;
                    if (!lat_we) req0_rdata <= ack_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_io_bus_sequencer.sv
// tb_io_bus_sequencer: table-driven and scoreboard checks of io_bus_sequencer with default
// timing (u_a) and a stretched SETUP/STROBE/HOLD instance (u_b).
module tb_io_bus_sequencer;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic [14:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        logic        sel;
    } req_t;

    typedef struct {
        logic        idx;
        logic        we;
        logic [14:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        logic        sel;
        logic [15:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        idx;
        logic        chk;
        logic [15:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    int unsigned total = 0;
    int unsigned bad   = 0;
    exp_t sb[$];
    exp_t sb_e;

    req_t a_r0, a_r1, b_r0, b_r1;
    logic        a_ack0, a_ack1, a_oe, a_rd_n, a_wr_n, a_csh_n, a_csl_n, a_sel;
    logic [15:0] a_rd0, a_rd1, a_wdata, a_bus_rdata;
    logic [14:0] a_addr;
    logic        b_ack0, b_ack1, b_oe, b_rd_n, b_wr_n, b_csh_n, b_csl_n, b_sel;
    logic [15:0] b_rd0, b_rd1, b_wdata, b_bus_rdata;
    logic [14:0] b_addr;

    function automatic logic [15:0] dev_val(input logic [14:0] a);
        return 16'hB54A ^ {a[7:0], a[7:0]};
    endfunction

    // Device model: data is only meaningful while the read strobe is low.
    assign a_bus_rdata = !a_rd_n ? dev_val(a_addr) : 16'hDEAD;
    assign b_bus_rdata = !b_rd_n ? dev_val(b_addr) : 16'hDEAD;

    io_bus_sequencer #(.ADDR_WIDTH(15), .SETUP_CYCLES(1), .STROBE_CYCLES(2), .HOLD_CYCLES(1)) u_a (
        .clk(clk), .reset(rst),
        .req0_valid(a_r0.valid), .req0_we(a_r0.we), .req0_addr(a_r0.addr),
        .req0_wdata(a_r0.wdata), .req0_be(a_r0.be), .req0_sel(a_r0.sel),
        .req0_ack(a_ack0), .req0_rdata(a_rd0),
        .req1_valid(a_r1.valid), .req1_we(a_r1.we), .req1_addr(a_r1.addr),
        .req1_wdata(a_r1.wdata), .req1_be(a_r1.be), .req1_sel(a_r1.sel),
        .req1_ack(a_ack1), .req1_rdata(a_rd1),
        .bus_addr(a_addr), .bus_wdata(a_wdata), .bus_data_oe(a_oe), .bus_rdata(a_bus_rdata),
        .bus_rd_n(a_rd_n), .bus_wr_n(a_wr_n), .bus_csh_n(a_csh_n), .bus_csl_n(a_csl_n),
        .bus_select_dev(a_sel)
    );

    io_bus_sequencer #(.ADDR_WIDTH(15), .SETUP_CYCLES(2), .STROBE_CYCLES(3), .HOLD_CYCLES(2)) u_b (
        .clk(clk), .reset(rst),
        .req0_valid(b_r0.valid), .req0_we(b_r0.we), .req0_addr(b_r0.addr),
        .req0_wdata(b_r0.wdata), .req0_be(b_r0.be), .req0_sel(b_r0.sel),
        .req0_ack(b_ack0), .req0_rdata(b_rd0),
        .req1_valid(b_r1.valid), .req1_we(b_r1.we), .req1_addr(b_r1.addr),
        .req1_wdata(b_r1.wdata), .req1_be(b_r1.be), .req1_sel(b_r1.sel),
        .req1_ack(b_ack1), .req1_rdata(b_rd1),
        .bus_addr(b_addr), .bus_wdata(b_wdata), .bus_data_oe(b_oe), .bus_rdata(b_bus_rdata),
        .bus_rd_n(b_rd_n), .bus_wr_n(b_wr_n), .bus_csh_n(b_csh_n), .bus_csl_n(b_csl_n),
        .bus_select_dev(b_sel)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s: no response within bound", nm);
    endtask

    // Scoreboard: every ack from u_a must match the next expected completion.
    always @(negedge clk) begin
        if (!rst && (a_ack0 || a_ack1)) begin
            if (a_ack0 && a_ack1) begin
                chk("dual_ack", {a_ack1, a_ack0}, 32'h1);
            end else if (sb.size() == 0) begin
                chk("ack_without_request", {a_ack1, a_ack0}, 32'h0);
            end else begin
                sb_e = sb.pop_front();
                chk("ack_idx", a_ack1, sb_e.idx);
                if (sb_e.chk) chk("ack_rdata", sb_e.idx ? a_rd1 : a_rd0, sb_e.rdata);
            end
        end
    end

    task automatic run_single(input vec_t v);
        int unsigned last;
        logic acc, strobe;
        req_t r;
        r = '{1'b1, v.we, v.addr, v.wdata, v.be, v.sel};
        @(posedge clk); #1;
        if (v.idx) a_r1 = r; else a_r0 = r;
        sb.push_back('{v.idx, (!v.we || v.be == 2'b00), v.exp_rdata});
        last = (v.be == 2'b00) ? 1 : 4;
        for (int unsigned k = 1; k <= last + 1; k++) begin
            @(posedge clk); #1;
            acc    = (v.be != 2'b00) && (k <= 4);
            strobe = acc && (k == 2 || k == 3);
            chk($sformatf("ctl[a=%h k=%0d]", v.addr, k),
                {a_csh_n, a_csl_n, a_rd_n, a_wr_n, a_oe, a_ack1, a_ack0},
                {(acc ? ~v.be[1] : 1'b1), (acc ? ~v.be[0] : 1'b1),
                 !(strobe && !v.we), !(strobe && v.we), (acc && v.we),
                 (k == last) && v.idx, (k == last) && !v.idx});
            if (acc) begin
                chk($sformatf("addr[k=%0d]", k), a_addr, v.addr);
                chk($sformatf("sel[k=%0d]", k), a_sel, v.sel);
                if (v.we) chk($sformatf("wdata[k=%0d]", k), a_wdata, v.wdata);
            end
        end
        a_r0.valid = 1'b0;
        a_r1.valid = 1'b0;
    endtask

    task automatic requester(input logic idx, input logic [14:0] base);
        logic got;
        req_t r;
        for (int unsigned n = 0; n < 4; n++) begin
            r = '{1'b1, 1'b0, base + 15'(n), 16'h0000, 2'b11, idx};
            if (idx) a_r1 = r; else a_r0 = r;
            got = 1'b0;
            for (int unsigned t = 0; t < 100 && !got; t++) begin
                @(negedge clk);
                got = idx ? a_ack1 : a_ack0;
            end
            if (!got) fail($sformatf("arb_timeout[%0d.%0d]", idx, n));
            @(posedge clk); #1;
        end
        if (idx) a_r1.valid = 1'b0; else a_r0.valid = 1'b0;
    endtask

    vec_t vecs[8];
    logic order[8];
    int unsigned low_cnt, first_low, ack_k, stray;
    logic [15:0] b_got;
    int unsigned n0, n1;

    initial begin
        vecs[0] = '{1'b0, 1'b1, 15'h1234, 16'hBEEF, 2'b11, 1'b1, 16'h0000};
        vecs[1] = '{1'b1, 1'b0, 15'h0010, 16'h0000, 2'b01, 1'b0, 16'h005A};
        vecs[2] = '{1'b0, 1'b0, 15'h00FF, 16'h0000, 2'b11, 1'b1, 16'h4AB5};
        vecs[3] = '{1'b1, 1'b0, 15'h0123, 16'h0000, 2'b10, 1'b0, 16'h9600};
        vecs[4] = '{1'b0, 1'b0, 15'h0055, 16'h0000, 2'b00, 1'b0, 16'h0000};
        vecs[5] = '{1'b1, 1'b1, 15'h7FFF, 16'h1357, 2'b10, 1'b1, 16'h0000};
        vecs[6] = '{1'b0, 1'b0, 15'h4000, 16'h0000, 2'b01, 1'b0, 16'h004A};
        vecs[7] = '{1'b1, 1'b1, 15'h0200, 16'h2468, 2'b00, 1'b1, 16'h0000};

        rst = 1'b1;
        a_r0 = '0; a_r1 = '0; b_r0 = '0; b_r1 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_strobes_cs", {a_csh_n, a_csl_n, a_rd_n, a_wr_n}, 32'hF);
        chk("rst_oe_sel_ack", {a_oe, a_sel, a_ack0, a_ack1}, 32'h0);
        chk("rst_addr_wdata", {a_addr, a_wdata}, 32'h0);
        chk("rst_rdata", {a_rd1, a_rd0}, 32'h0);
        rst = 1'b0;

        for (int unsigned i = 0; i < 8; i++) run_single(vecs[i]);
        chk("rdata0_final", a_rd0, 16'h004A);
        chk("rdata1_final", a_rd1, 16'h0000);

        // Reset during the second STROBE cycle of a write drops the access.
        @(posedge clk); #1;
        a_r0 = '{1'b1, 1'b1, 15'h0ABC, 16'h5555, 2'b11, 1'b0};
        repeat (3) @(posedge clk);
        #1;
        chk("wr_low_before_reset", {a_wr_n, a_rd_n}, 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        a_r0.valid = 1'b0;
        chk("reset_abort_bus", {a_csh_n, a_csl_n, a_rd_n, a_wr_n, a_oe, a_ack1, a_ack0}, 32'h78);
        @(posedge clk); #1;
        chk("reset_abort_after", {a_csh_n, a_csl_n, a_rd_n, a_wr_n, a_oe, a_ack1, a_ack0}, 32'h78);
        run_single('{1'b0, 1'b1, 15'h0321, 16'hCAFE, 2'b01, 1'b1, 16'h0000});

        // Contention: both requesters issue 4 reads each from the same cycle.
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
`ifdef IO_SEQ_ROUND_ROBIN_EN
        for (int unsigned i = 0; i < 8; i++) order[i] = i[0];
`else
        for (int unsigned i = 0; i < 8; i++) order[i] = (i >= 4);
`endif
        n0 = 0; n1 = 0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (order[i]) begin
                sb.push_back('{1'b1, 1'b1, dev_val(15'h0200 + 15'(n1))});
                n1++;
            end else begin
                sb.push_back('{1'b0, 1'b1, dev_val(15'h0100 + 15'(n0))});
                n0++;
            end
        end
        fork
            requester(1'b0, 15'h0100);
            requester(1'b1, 15'h0200);
        join
        repeat (3) @(posedge clk);
        chk("sb_drained", sb.size(), 32'h0);

        // Stretched timing instance: 2 SETUP, 3 STROBE, 2 HOLD.
        @(posedge clk); #1;
        b_r0 = '{1'b1, 1'b0, 15'h0033, 16'h0000, 2'b11, 1'b1};
        low_cnt = 0; first_low = 0; ack_k = 0; stray = 0; b_got = '0;
        for (int unsigned k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (!b_rd_n) begin
                low_cnt++;
                if (first_low == 0) first_low = k;
            end
            if (!b_wr_n || b_oe || b_ack1) stray++;
            if (k == 1) chk("b_cs_setup", {b_csh_n, b_csl_n, b_sel}, 32'h1);
            if (b_ack0 && ack_k == 0) begin
                ack_k = k;
                b_got = b_rd0;
            end
            if (ack_k != 0 && k == ack_k + 1) b_r0.valid = 1'b0;
        end
        b_r0.valid = 1'b0;
        chk("b_rd_low_cycles", low_cnt, 32'd3);
        chk("b_rd_first_low", first_low, 32'd3);
        chk("b_ack_cycle", ack_k, 32'd7);
        chk("b_rdata", b_got, 16'h8679);
        chk("b_stray_activity", stray, 32'd0);
        chk("b_idle_after", {b_csh_n, b_csl_n, b_rd_n, b_wr_n, b_wdata, b_rd1}, 32'hF << 32);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
